alarm_sequencer: RTL and testbench
==================================

// Module: alarm_sequencer
// PURPOSE
//  Owns the alarm setting and sequences the buzzer around the alarm-time comparator.
//  Holds amin/ahrs, arming state, ring-duration timer and snooze timer.
//  Feeds amin/ahrs/alarmon to the comparator and takes its match level back.
//  Sits between the user buttons (debounced single-cycle pulses) and the buzzer driver.
// PARAMETERS
//  RING_SECS   60  seconds buzz stays on before auto-silence (>=1)
//  SNOOZE_MIN  9   snooze length in minutes; timer loads SNOOZE_MIN*60 ticks (>=1)
//  MAX_SNOOZE  3   snoozes allowed per alarm event (>=1)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous reset, active low
//  tick_sec    in   1   1-cycle pulse, once per second
//  match       in   1   comparator level: time == alarm time (high for a whole minute)
//  arm_toggle  in   1   pulse: toggle armed/off
//  adv_min     in   1   pulse: amin = (amin+1) mod 60
//  adv_hrs     in   1   pulse: ahrs = (ahrs+1) mod 24
//  snooze      in   1   pulse: snooze request
//  stop        in   1   pulse: silence and re-arm
//  amin        out  7   alarm minute, 0..59
//  ahrs        out  7   alarm hour, 0..23
//  alarmon     out  1   1 in every state except OFF
//  buzz        out  1   1 iff state==RINGING
//  state       out  2   OFF=0 ARMED=1 RINGING=2 SNOOZE=3
//  snooze_cnt  out  $clog2(MAX_SNOOZE+1)  snoozes used in the current event
// BEHAVIOUR
//  Reset (async, rst_n=0): state=OFF, amin=0, ahrs=0, timer=0, snooze_cnt=0, match_q=0.
//   All outputs are 0 while reset is held. Reset mid-ring kills buzz immediately.
//  match_q <= match every cycle in all states. Edge fire = match & ~match_q.
//   Arming during an active match minute does not ring until the next match rise.
//  Shared down-counter timer: width TW = $clog2(max(RING_SECS, SNOOZE_MIN*60)+1).
//  Per-state priority, highest first: arm_toggle > stop > snooze > fire/tick.
//  OFF:     arm_toggle -> ARMED. All other pulses are ignored except adv_*.
//  ARMED:   arm_toggle -> OFF.
//           fire -> RINGING, timer=RING_SECS, snooze_cnt=0.
//  RINGING: arm_toggle -> OFF.
//           stop -> ARMED.
//           snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE, timer=SNOOZE_MIN*60, snooze_cnt+1.
//           snooze with snooze_cnt==MAX_SNOOZE: ignored.
//           tick_sec with timer==1 -> ARMED (auto-silence); otherwise tick_sec decrements timer.
//           A snooze pulse in the same cycle as timeout: snooze wins.
//  SNOOZE:  arm_toggle -> OFF.
//           stop -> ARMED.
//           tick_sec with timer==1 -> RINGING, timer=RING_SECS, snooze_cnt held.
//           Otherwise tick_sec decrements timer.
//  Entering ARMED or OFF clears timer. snooze_cnt holds until the next fire.
//  adv_min/adv_hrs act only in OFF/ARMED; they are ignored in RINGING/SNOOZE.
//   Wraparound: 59->0 and 23->0, with no carry between them.
//   Both pulses in the same cycle: both fields advance.
//   If an adjust makes match rise while ARMED, it rings (normal fire).
//  Latency: fire sampled at edge N -> state/buzz change visible after edge N.
//   buzz decodes the state register (glitch-free). Button pulses take effect in one cycle.
//  Pulses wider than 1 cycle are the caller's fault; each high cycle counts as a pulse.
// TESTING  (RING_SECS=5, SNOOZE_MIN=1, MAX_SNOOZE=2)
//  Reset, 59 adv_min + 25 adv_hrs -> amin=59 then 0 on the 60th pulse; ahrs=1; alarmon=0.
//  Arm, raise match -> buzz=1 next cycle; 5 tick_sec -> buzz=0, state=ARMED.
//   match held high: no re-ring.
//  Ringing, snooze -> state=3, buzz=0; 60 ticks -> buzz=1, snooze_cnt=1; snooze, 60 ticks
//   -> snooze_cnt=2; third snooze ignored, buzz stays 1.
//  Ringing, snooze+stop same cycle -> ARMED, buzz=0. arm_toggle+stop -> OFF, alarmon=0.
//  Arm while match=1 -> no buzz. Drop match, raise it again -> buzz=1.
//  rst_n low mid-SNOOZE, asynchronously between clock edges -> all outputs 0 immediately.
//   Release -> OFF, amin=ahrs=0.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm setting registers and buzzer sequencer (OFF/ARMED/RINGING/SNOOZE).
// Rings on the rising edge of the comparator match level and handles snooze and auto-silence.
module alarm_sequencer #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tick_sec,
  input  logic                            match,
  input  logic                            arm_toggle,
  input  logic                            adv_min,
  input  logic                            adv_hrs,
  input  logic                            snooze,
  input  logic                            stop,
  output logic [6:0]                      amin,
  output logic [6:0]                      ahrs,
  output logic                            alarmon,
  output logic                            buzz,
  output logic [1:0]                      state,
  output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_cnt
);

  localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int unsigned TMAX      = (RING_SECS > SNZ_TICKS) ? RING_SECS : SNZ_TICKS;
  localparam int unsigned TW        = $clog2(TMAX + 1);
  localparam int unsigned CW        = $clog2(MAX_SNOOZE + 1);

  localparam logic [TW-1:0] T_RING = TW'(RING_SECS);
  localparam logic [TW-1:0] T_SNZ  = TW'(SNZ_TICKS);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_SNOOZE);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      amin_q, amin_d;
  logic [6:0]      ahrs_q, ahrs_d;
  logic            match_q;
  logic            fire;

  assign fire = match & ~match_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    amin_d  = amin_q;
    ahrs_d  = ahrs_q;

    if (state_q == OFF || state_q == ARMED) begin
      if (adv_min) amin_d = (amin_q == 7'd59) ? '0 : amin_q + 7'd1;
      if (adv_hrs) ahrs_d = (ahrs_q == 7'd23) ? '0 : ahrs_q + 7'd1;
    end

    unique case (state_q)
      OFF: begin
        if (arm_toggle) begin
          state_d = ARMED;
          timer_d = '0;
        end
      end
      ARMED: begin
        if (arm_toggle) begin
          state_d = OFF;
          timer_d = '0;
        end else if (fire) begin
          state_d = RINGING;
          timer_d = T_RING;
          cnt_d   = '0;
        end
      end
      RINGING: begin
        if (arm_toggle) begin
          state_d = OFF;
          timer_d = '0;
        end else if (stop) begin
          state_d = ARMED;
          timer_d = '0;
        end else if (snooze && cnt_q < C_MAX) begin
          state_d = SNOOZE;
          timer_d = T_SNZ;
          cnt_d   = cnt_q + C_ONE;
        end else if (tick_sec) begin
          // an exhausted snooze falls through here, so the ring timer keeps running
          if (timer_q == T_ONE) begin
            state_d = ARMED;
            timer_d = '0;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      SNOOZE: begin
        if (arm_toggle) begin
          state_d = OFF;
          timer_d = '0;
        end else if (stop) begin
          state_d = ARMED;
          timer_d = '0;
        end else if (tick_sec) begin
          if (timer_q == T_ONE) begin
            state_d = RINGING;
            timer_d = T_RING;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      timer_q <= '0;
      cnt_q   <= '0;
      amin_q  <= '0;
      ahrs_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      amin_q  <= amin_d;
      ahrs_q  <= ahrs_d;
      match_q <= match;
    end
  end

  assign amin       = amin_q;
  assign ahrs       = ahrs_q;
  assign state      = state_q;
  assign alarmon    = (state_q != OFF);
  assign buzz       = (state_q == RINGING);
  assign snooze_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with RING_SECS=5, SNOOZE_MIN=1, MAX_SNOOZE=2.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_sec = 1'b0, match = 1'b0, arm_toggle = 1'b0;
  logic       adv_min = 1'b0, adv_hrs = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [6:0] amin, ahrs;
  logic       alarmon, buzz;
  logic [1:0] state;
  logic [1:0] snooze_cnt;

  int unsigned checks = 0;
  int unsigned failures = 0;

  alarm_sequencer #(
    .RING_SECS (5),
    .SNOOZE_MIN(1),
    .MAX_SNOOZE(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_sec  (tick_sec),
    .match     (match),
    .arm_toggle(arm_toggle),
    .adv_min   (adv_min),
    .adv_hrs   (adv_hrs),
    .snooze    (snooze),
    .stop      (stop),
    .amin      (amin),
    .ahrs      (ahrs),
    .alarmon   (alarmon),
    .buzz      (buzz),
    .state     (state),
    .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    tick_sec = 1'b1;
    repeat (n) cyc();
    tick_sec = 1'b0;
  endtask

  initial begin
    // reset held: everything low
    #3;
    chk("rst_state", state, 0);
    chk("rst_buzz", buzz, 0);
    chk("rst_alarmon", alarmon, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rel_state", state, 0);
    chk("rel_amin", amin, 0);
    chk("rel_ahrs", ahrs, 0);
    chk("rel_cnt", snooze_cnt, 0);

    // alarm-time adjust and wraparound
    adv_min = 1'b1; repeat (59) cyc(); adv_min = 1'b0;
    chk("amin_59", amin, 59);
    adv_min = 1'b1; cyc(); adv_min = 1'b0;
    chk("amin_wrap", amin, 0);
    chk("ahrs_nocarry", ahrs, 0);
    adv_hrs = 1'b1; repeat (25) cyc(); adv_hrs = 1'b0;
    chk("ahrs_wrap", ahrs, 1);
    chk("adj_alarmon", alarmon, 0);
    adv_min = 1'b1; adv_hrs = 1'b1; cyc(); adv_min = 1'b0; adv_hrs = 1'b0;
    chk("both_amin", amin, 1);
    chk("both_ahrs", ahrs, 2);

    // arm, fire, auto-silence after 5 ticks
    arm_toggle = 1'b1; cyc(); arm_toggle = 1'b0;
    chk("arm_state", state, 1);
    chk("arm_alarmon", alarmon, 1);
    match = 1'b1; cyc();
    chk("fire_buzz", buzz, 1);
    chk("fire_state", state, 2);
    ticks(4);
    chk("ring_4ticks", buzz, 1);
    ticks(1);
    chk("timeout_buzz", buzz, 0);
    chk("timeout_state", state, 1);
    repeat (3) cyc();
    chk("no_rering", state, 1);
    match = 1'b0; cyc();

    // snooze cycle
    match = 1'b1; cyc();
    chk("ring2_state", state, 2);
    adv_min = 1'b1; cyc(); adv_min = 1'b0;
    chk("adj_ignored_ring", amin, 1);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snz1_state", state, 3);
    chk("snz1_buzz", buzz, 0);
    chk("snz1_cnt", snooze_cnt, 1);
    ticks(59);
    chk("snz1_59", state, 3);
    ticks(1);
    chk("snz1_end_buzz", buzz, 1);
    chk("snz1_end_cnt", snooze_cnt, 1);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snz2_state", state, 3);
    ticks(60);
    chk("snz2_end_state", state, 2);
    chk("snz2_end_cnt", snooze_cnt, 2);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snz3_ignored", state, 2);
    chk("snz3_buzz", buzz, 1);
    chk("snz3_cnt", snooze_cnt, 2);

    // stop beats snooze; count holds until next fire
    snooze = 1'b1; stop = 1'b1; cyc(); snooze = 1'b0; stop = 1'b0;
    chk("stop_snz_state", state, 1);
    chk("stop_snz_buzz", buzz, 0);
    chk("cnt_hold", snooze_cnt, 2);
    match = 1'b0; cyc();
    match = 1'b1; cyc();
    chk("refire_state", state, 2);
    chk("refire_cnt", snooze_cnt, 0);

    // snooze in the same cycle as timeout wins
    ticks(4);
    chk("pre_timeout", state, 2);
    snooze = 1'b1; tick_sec = 1'b1; cyc(); snooze = 1'b0; tick_sec = 1'b0;
    chk("snz_vs_timeout", state, 3);
    chk("snz_vs_timeout_cnt", snooze_cnt, 1);

    // arm_toggle beats stop
    arm_toggle = 1'b1; stop = 1'b1; cyc(); arm_toggle = 1'b0; stop = 1'b0;
    chk("arm_stop_state", state, 0);
    chk("arm_stop_alarmon", alarmon, 0);

    // arming during an active match minute waits for the next rise
    arm_toggle = 1'b1; cyc(); arm_toggle = 1'b0;
    repeat (3) cyc();
    chk("arm_in_match", state, 1);
    chk("arm_in_match_buzz", buzz, 0);
    match = 1'b0; cyc();
    match = 1'b1; cyc();
    chk("next_rise_buzz", buzz, 1);

    // asynchronous reset mid-snooze
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("pre_rst_state", state, 3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_amin", amin, 0);
    chk("async_ahrs", ahrs, 0);
    chk("async_alarmon", alarmon, 0);
    chk("async_buzz", buzz, 0);
    chk("async_cnt", snooze_cnt, 0);
    match = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_state", state, 0);
    chk("post_rst_amin", amin, 0);
    chk("post_rst_ahrs", ahrs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
